// File: rtl/hall_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : hall_tracker_if
// Brief    : Hall input / position-status bundle between pins, tracker and regs
// Revision : 1.0 - initial release
// ============================================================================
interface hall_tracker_if #(
    parameter int COUNT_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16
);
    logic [2:0]              hall;
    logic                    clear_fault;
    logic [COUNT_WIDTH-1:0]  count;
    logic                    step_up;
    logic                    step_down;
    logic                    direction;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    fault;
    logic                    fault_sticky;

    modport master (
        output hall, clear_fault,
        input  count, step_up, step_down, direction,
        input  period, period_valid, fault, fault_sticky
    );

    modport slave (
        input  hall, clear_fault,
        output count, step_up, step_down, direction,
        output period, period_valid, fault, fault_sticky
    );
endinterface
`default_nettype wire

// File: rtl/hall_tracker.sv
`default_nettype none
// ============================================================================
// Module   : hall_tracker
// Brief    : Hall deglitch, six-step position tracking, step period and faults
// Revision : 1.0 - initial release
// ============================================================================
module hall_tracker #(
    parameter int COUNT_WIDTH   = 16,
    parameter int PERIOD_WIDTH  = 16,
    parameter int FILTER_CYCLES = 4,
    parameter int DIR_INVERT    = 0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    hall_tracker_if.slave bus
);
    localparam int                      c_FCW      = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
    localparam logic [c_FCW-1:0]        c_FLT_LAST = c_FCW'(FILTER_CYCLES - 1);
    localparam logic [c_FCW-1:0]        c_FLT_ONE  = c_FCW'(1);
    localparam logic [COUNT_WIDTH-1:0]  c_CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] c_PER_ONE  = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] c_PER_MAX  = '1;
    localparam logic [2:0]              c_IDX_BAD  = 3'd7;

    // Position of a hall code in the forward sequence; 000/111 map to c_IDX_BAD.
    function automatic logic [2:0] f_idx(input logic [2:0] s);
        case (s)
            3'b101:  f_idx = 3'd0;
            3'b100:  f_idx = 3'd1;
            3'b110:  f_idx = 3'd2;
            3'b010:  f_idx = 3'd3;
            3'b011:  f_idx = 3'd4;
            3'b001:  f_idx = 3'd5;
            default: f_idx = c_IDX_BAD;
        endcase
    endfunction

    logic [2:0]              r_sync1;
    logic [2:0]              r_hs;
    logic [2:0]              r_hs_prev;
    logic [2:0]              r_state;
    logic [c_FCW-1:0]        r_fcnt;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    r_step_up;
    logic                    r_step_down;
    logic                    r_dir;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    r_period_valid;
    logic                    r_fault;
    logic                    r_fault_sticky;
    logic [PERIOD_WIDTH-1:0] r_timer;
    logic                    r_ref_ok;

    logic       w_qual;
    logic       w_accept;
    logic [2:0] w_idx_old;
    logic [2:0] w_idx_new;
    logic       w_old_legal;
    logic       w_new_legal;
    logic [2:0] w_succ;
    logic [2:0] w_pred;
    logic       w_seq_fwd;
    logic       w_seq_bwd;
    logic       w_up;
    logic       w_down;
    logic       w_step;
    logic       w_fault;
    logic       w_same_dir;

    assign w_qual      = (r_hs != r_state) && (r_hs == r_hs_prev);
    assign w_accept    = w_qual && (r_fcnt == c_FLT_LAST);

    assign w_idx_old   = f_idx(r_state);
    assign w_idx_new   = f_idx(r_hs);
    assign w_old_legal = (w_idx_old != c_IDX_BAD);
    assign w_new_legal = (w_idx_new != c_IDX_BAD);
    assign w_succ      = (w_idx_old == 3'd5) ? 3'd0 : (w_idx_old + 3'd1);
    assign w_pred      = (w_idx_old == 3'd0) ? 3'd5 : (w_idx_old - 3'd1);
    assign w_seq_fwd   = w_old_legal && w_new_legal && (w_idx_new == w_succ);
    assign w_seq_bwd   = w_old_legal && w_new_legal && (w_idx_new == w_pred);

    assign w_up        = w_accept && ((DIR_INVERT != 0) ? w_seq_bwd : w_seq_fwd);
    assign w_down      = w_accept && ((DIR_INVERT != 0) ? w_seq_fwd : w_seq_bwd);
    assign w_step      = w_up || w_down;
    // An unknown reference (000/111) only faults if the new code is itself illegal.
    assign w_fault     = w_accept && (!w_new_legal || (w_old_legal && !w_seq_fwd && !w_seq_bwd));
    assign w_same_dir  = r_ref_ok && (r_dir == w_up);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1        <= 3'b000;
            r_hs           <= 3'b000;
            r_hs_prev      <= 3'b000;
            r_state        <= 3'b000;
            r_fcnt         <= '0;
            r_count        <= '0;
            r_step_up      <= 1'b0;
            r_step_down    <= 1'b0;
            r_dir          <= 1'b0;
            r_period       <= c_PER_MAX;
            r_period_valid <= 1'b0;
            r_fault        <= 1'b0;
            r_fault_sticky <= 1'b0;
            r_timer        <= '0;
            r_ref_ok       <= 1'b0;
        end else begin
            r_sync1   <= bus.hall;
            r_hs      <= r_sync1;
            r_hs_prev <= r_hs;

            if (w_accept || !w_qual) begin
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + c_FLT_ONE;
            end

            if (w_accept) begin
                r_state <= r_hs;
            end

            r_step_up   <= w_up;
            r_step_down <= w_down;
            r_fault     <= w_fault;

            if (w_up) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_down) begin
                r_count <= r_count - c_CNT_ONE;
            end

            if (w_step) begin
                r_dir <= w_up;
            end

            // A clear during the visible fault pulse is ignored.
            if (w_fault) begin
                r_fault_sticky <= 1'b1;
            end else if (bus.clear_fault && !r_fault) begin
                r_fault_sticky <= 1'b0;
            end

            if (w_step || w_fault) begin
                r_timer <= c_PER_ONE;
            end else if (r_timer != c_PER_MAX) begin
                r_timer <= r_timer + c_PER_ONE;
            end

            if (w_step) begin
                r_ref_ok <= 1'b1;
                if (w_same_dir) begin
                    r_period       <= r_timer;
                    r_period_valid <= 1'b1;
                end else begin
                    r_period_valid <= 1'b0;
                end
            end else if (w_fault) begin
                r_ref_ok       <= 1'b0;
                r_period_valid <= 1'b0;
            end else if (r_timer == c_PER_MAX) begin
                // Stall: the next step has no trustworthy start time.
                r_ref_ok       <= 1'b0;
                r_period       <= c_PER_MAX;
                r_period_valid <= 1'b0;
            end
        end
    end

    assign bus.count        = r_count;
    assign bus.step_up      = r_step_up;
    assign bus.step_down    = r_step_down;
    assign bus.direction    = r_dir;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.fault        = r_fault;
    assign bus.fault_sticky = r_fault_sticky;
endmodule
`default_nettype wire

// File: tb/tb_hall_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_hall_tracker
// Brief    : Directed scoreboard bench for hall_tracker
// Revision : 1.0 - initial release
// ============================================================================
module tb_hall_tracker;
    localparam int CW  = 16;
    localparam int PW  = 8;
    localparam int FC  = 4;
    // Edges from the first clock edge that samples a new hall value to the output update.
    localparam int LAT = FC + 2;
    localparam logic [17:0] FWD_SEQ = {3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    localparam logic [PW-1:0] PMAX = '1;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [2:0]    kind;   // {fault, step_down, step_up}
        logic [CW-1:0] count;
        logic          dir;
        logic [PW-1:0] period;
        logic          pv;
    } ev_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc   = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_up_seen = 0;
    ev_t         sb[$];

    logic [2:0]    m_state;
    logic [CW-1:0] m_count;
    logic          m_dir;
    logic          m_pv;
    logic          m_ref;
    logic [PW-1:0] m_period;
    int unsigned   m_last;

    hall_tracker_if #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) u_if ();

    hall_tracker #(
        .COUNT_WIDTH  (CW),
        .PERIOD_WIDTH (PW),
        .FILTER_CYCLES(FC),
        .DIR_INVERT   (0)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int seq_pos(input logic [2:0] s);
        logic [17:0] tbl;
        tbl = FWD_SEQ;
        seq_pos = -1;
        for (int i = 0; i < 6; i++) begin
            if (tbl[17-3*i -: 3] == s) seq_pos = i;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 3'b000;
        m_count  = '0;
        m_dir    = 1'b0;
        m_pv     = 1'b0;
        m_ref    = 1'b0;
        m_period = PMAX;
        m_last   = cyc;
    endtask

    task automatic chk_reset(input string p);
        chk({p, ".count"},  32'(u_if.count), 32'd0);
        chk({p, ".up"},     32'(u_if.step_up), 32'd0);
        chk({p, ".down"},   32'(u_if.step_down), 32'd0);
        chk({p, ".fault"},  32'(u_if.fault), 32'd0);
        chk({p, ".sticky"}, 32'(u_if.fault_sticky), 32'd0);
        chk({p, ".dir"},    32'(u_if.direction), 32'd0);
        chk({p, ".period"}, 32'(u_if.period), 32'(PMAX));
        chk({p, ".pv"},     32'(u_if.period_valid), 32'd0);
    endtask

    // Drive a hall code (called #1 after a rising edge), predict its outcome, hold it.
    task automatic drive(input logic [2:0] h, input int hold);
        int  po, pn;
        bit  ev;
        ev_t e;
        int unsigned delta;
        po = seq_pos(m_state);
        pn = seq_pos(h);
        ev = (h != m_state);
        e  = '0;
        e.cyc = cyc + 1 + LAT;
        if (!ev)                  e.kind = 3'b000;
        else if (pn < 0)          e.kind = 3'b100;
        else if (po < 0)          ev = 1'b0;
        else if (pn == (po+1)%6)  e.kind = 3'b001;
        else if (pn == (po+5)%6)  e.kind = 3'b010;
        else                      e.kind = 3'b100;
        m_state = h;
        if (ev) begin
            delta = e.cyc - m_last;
            if (delta > 32'(PMAX)) begin
                m_period = PMAX;
                m_pv     = 1'b0;
                m_ref    = 1'b0;
            end
            if (e.kind == 3'b100) begin
                m_ref = 1'b0;
                m_pv  = 1'b0;
            end else begin
                if (m_ref && (m_dir == e.kind[0])) begin
                    m_period = PW'(delta);
                    m_pv     = 1'b1;
                end else begin
                    m_pv = 1'b0;
                end
                m_dir   = e.kind[0];
                m_ref   = 1'b1;
                m_count = e.kind[0] ? m_count + 1'b1 : m_count - 1'b1;
            end
            m_last   = e.cyc;
            e.count  = m_count;
            e.dir    = m_dir;
            e.period = m_period;
            e.pv     = m_pv;
            sb.push_back(e);
        end
        u_if.hall = h;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        chk("sb_empty_before_reset", 32'(sb.size()), 32'd0);
        u_if.hall = 3'b000;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        ev_t got;
        ev_t exp;
        if (!reset && (u_if.step_up || u_if.step_down || u_if.fault)) begin
            got.cyc    = cyc;
            got.kind   = {u_if.fault, u_if.step_down, u_if.step_up};
            got.count  = u_if.count;
            got.dir    = u_if.direction;
            got.period = u_if.period;
            got.pv     = u_if.period_valid;
            if (u_if.step_up) n_up_seen++;
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: got kind=%b count=%h at cyc %0d, expected no event",
                       got.kind, got.count, got.cyc);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                n_tests++;
                assert (got === exp) else begin
                    n_fail++;
                    $error("FAIL sb_event: got cyc=%0d kind=%b cnt=%h dir=%b per=%h pv=%b, expected cyc=%0d kind=%b cnt=%h dir=%b per=%h pv=%b",
                           got.cyc, got.kind, got.count, got.dir, got.period, got.pv,
                           exp.cyc, exp.kind, exp.count, exp.dir, exp.period, exp.pv);
                end
            end
        end
    end

    initial begin
        u_if.hall        = 3'b000;
        u_if.clear_fault = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        chk_reset("rst");
        reset = 1'b0;
        model_reset();

        // Forward run: adopt 101, then 12 forward steps.
        drive(3'b101, 10);
        for (int i = 0; i < 12; i++) begin
            drive(FWD_SEQ[17-3*((i+1)%6) -: 3], 20);
        end
        chk("fwd.count", 32'(u_if.count), 32'd12);
        chk("fwd.ups", 32'(n_up_seen), 32'd12);
        chk("fwd.dir", 32'(u_if.direction), 32'd1);
        chk("fwd.period", 32'(u_if.period), 32'd20);
        chk("fwd.pv", 32'(u_if.period_valid), 32'd1);

        // Backward step from zero wraps.
        pulse_reset();
        drive(3'b101, 10);
        drive(3'b001, 20);
        chk("bwd.count", 32'(u_if.count), 32'h0000_FFFF);
        chk("bwd.dir", 32'(u_if.direction), 32'd0);
        chk("bwd.pv", 32'(u_if.period_valid), 32'd0);

        // Glitch rejection on 100, then an exactly-long-enough pulse.
        drive(3'b101, 20);
        drive(3'b100, 20);
        for (int i = 0; i < 3; i++) begin
            u_if.hall = 3'b110;
            repeat (2) @(posedge clk);
            #1;
            u_if.hall = 3'b100;
            repeat (10) @(posedge clk);
            #1;
        end
        chk("glitch.count", 32'(u_if.count), 32'd1);
        chk("glitch.sticky", 32'(u_if.fault_sticky), 32'd0);
        drive(3'b110, 6);
        drive(3'b100, 20);
        chk("pulse.count", 32'(u_if.count), 32'd1);

        // Skip and illegal codes, sticky fault handling.
        drive(3'b101, 20);
        drive(3'b110, 20);
        drive(3'b111, 20);
        chk("skip.count", 32'(u_if.count), 32'd0);
        chk("skip.sticky", 32'(u_if.fault_sticky), 32'd1);
        drive(3'b000, LAT + 1);
        chk("clr.fault_now", 32'(u_if.fault), 32'd1);
        u_if.clear_fault = 1'b1;
        @(posedge clk);
        #1;
        u_if.clear_fault = 1'b0;
        chk("clr.with_fault", 32'(u_if.fault_sticky), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        u_if.clear_fault = 1'b1;
        @(posedge clk);
        #1;
        u_if.clear_fault = 1'b0;
        chk("clr.alone", 32'(u_if.fault_sticky), 32'd0);

        // Stall: hold one state beyond the period range.
        drive(3'b101, 10);
        drive(3'b100, 20);
        drive(3'b110, 300);
        chk("stall.period", 32'(u_if.period), 32'(PMAX));
        chk("stall.pv", 32'(u_if.period_valid), 32'd0);
        drive(3'b010, 20);
        chk("stall.next_pv", 32'(u_if.period_valid), 32'd0);
        drive(3'b011, 20);
        chk("stall.after_pv", 32'(u_if.period_valid), 32'd1);
        chk("stall.after_period", 32'(u_if.period), 32'd20);

        // Asynchronous reset in the middle of a run.
        pulse_reset();
        drive(3'b101, 10);
        for (int i = 1; i < 6; i++) begin
            drive(FWD_SEQ[17-3*i -: 3], 20);
        end
        chk("mid.count_before", 32'(u_if.count), 32'd5);
        chk("sb_empty_mid", 32'(sb.size()), 32'd0);
        reset = 1'b1;
        #2;
        chk_reset("midrst");
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        drive(3'b001, 20);
        chk("mid.adopt_count", 32'(u_if.count), 32'd0);
        drive(3'b101, 20);
        chk("mid.step_count", 32'(u_if.count), 32'd1);
        chk("mid.step_pv", 32'(u_if.period_valid), 32'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hall_tracker.md
Name: hall_tracker

Overview:
Parametrised successor to the 3-bit hall step counter used by the motor drive logic. It synchronises and deglitches the raw hall inputs, then tracks signed position over the six-step commutation sequence. It measures the step period for speed estimation and reports transient and sticky faults. One instance sits per motor, between the hall input pins and the motor-control register block.

Parameters:
COUNT_WIDTH, 16, width of position counter (wraps modulo 2^COUNT_WIDTH)
PERIOD_WIDTH, 16, width of step-period timer/output (saturating)
FILTER_CYCLES, 4, consecutive stable cycles required before a hall change is accepted (>=1)
DIR_INVERT, 0, 1 swaps forward/backward classification

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hall  in  3  raw hall sensor inputs (asynchronous to clk)
clear_fault  in  1  clears fault_sticky
count  out  COUNT_WIDTH  position, +1 per forward step, -1 per backward step
step_up  out  1  one-cycle pulse on accepted forward step
step_down  out  1  one-cycle pulse on accepted backward step
direction  out  1  direction of last accepted step (1 = forward)
period  out  PERIOD_WIDTH  clk cycles between last two same-direction steps
period_valid  out  1  period holds a valid measurement
fault  out  1  one-cycle pulse on illegal accepted state or skipped step
fault_sticky  out  1  latched fault, held until clear_fault

Behaviour:
- Reset (async assert, release synchronous to clk): sync regs 0, filtered state 000 (unknown), filter counter 0, count 0, step_up/step_down/fault 0, fault_sticky 0, direction 0, period all-ones, period_valid 0, timer 0.
- Input path: 2-flop synchroniser on hall -> hs.
- Filter: when hs != filtered state and hs equals its previous-cycle value, the filter counter increments; any other cycle resets it to 0. When the counter reaches FILTER_CYCLES, hs is accepted: filtered state <= hs and the counter is cleared. All outputs update on that same edge. Hall change to count change = FILTER_CYCLES+2 clk cycles.
- Forward sequence: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101. Backward is the reverse. DIR_INVERT=1 swaps the two classes.
- On an accepted state, evaluated against the previous filtered state:
  - Previous state 000 (unknown, only after reset or after an illegal state) and new state legal: adopt the new state; no step, no fault.
  - New state 000 or 111: fault pulse; count unchanged; adopt as reference (treated as unknown).
  - Forward neighbour: count+1 (wrap all-ones -> 0), step_up=1, direction=1.
  - Backward neighbour: count-1 (wrap 0 -> all-ones), step_down=1, direction=0.
  - Any other legal state (skip): fault pulse; count unchanged; adopt the new state as reference.
- step_up, step_down and fault are high for exactly one cycle. They are mutually exclusive.
- fault_sticky: set on any fault pulse. Cleared on a cycle with clear_fault=1 and no fault pulse. Set wins over clear.
- Period timer: increments every cycle, saturating at all-ones. It resets to 1 on the edge of any accepted step or fault.
  - Step in the same direction as the previous step: period <= timer, period_valid=1.
  - Step that reverses direction, first step after unknown, or fault: period_valid=0, period unchanged.
  - Timer reaching all-ones (stall): period <= all-ones, period_valid=0.
- Reset mid-operation: all state returns to reset values immediately. The first legal state after release produces no step.

Test Plan:
- Reset, hold hall=101 for 10 cycles, then step the forward sequence 12 times holding each state 20 cycles. Required: first 101 produces no step; count=12, 12 step_up pulses, direction=1, period=20, period_valid=1 after the second step.
- From count=0, one backward step (101->001). Required: count=all-ones (0xFFFF), step_down pulse, period_valid=0.
- Hall=100 with 2-cycle glitches to 110, FILTER_CYCLES=4. Required: no step, no fault, count unchanged. A 6-cycle pulse of 110 is accepted, giving count+1 exactly FILTER_CYCLES+2 cycles after the hall change.
- Jump 101->110 (skip), then hall=111. Required: two fault pulses, count unchanged, fault_sticky=1. clear_fault asserted on the same cycle as a fault leaves fault_sticky=1; asserted alone, it clears.
- Hold a legal state for more than 2^PERIOD_WIDTH cycles (use PERIOD_WIDTH=8, hold 300). Required: period=0xFF, period_valid=0. Next same-direction step leaves period_valid=0; the step after that gives a valid period.
- Assert reset mid-sequence at count=5. Required: all outputs return to reset values immediately. After release, the first legal state produces no step.
